prach_hb2_demux: RTL and testbench
==================================

Name: prach_hb2_demux

Overview:
- Polyphase commutator directly upstream of the second half-band decimator channel stage.
- Takes the single TDM sample stream (one 16-bit sample per channel slot) at the pre-decimation rate.
- Pairs each channel's consecutive samples x[2n], x[2n+1] and presents them together as dout_dp1/dout_dp2 with one dout_dv per pair, at half rate.
- Output interface matches the half-band stage's din_dp1/din_dp2/din_dv/din_chn/sync_in exactly.

Parameters:
- NumChannel, 32, TDM slots per frame (din_chn range 0..NumChannel-1).
- NumChannelUsed, 24, channels carrying data; slots >= this are ignored.
- DataWidth, 16, sample width (signed, passed through untouched).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- din_dq  in  16  input sample.
- din_dv  in  1  input sample valid.
- din_chn  in  8  input channel index.
- sync_in  in  1  frame start; qualified by din_dv, marks an even-phase (x[2n]) frame start.
- dout_dp1  out  16  even-phase sample x[2n] of dout_chn.
- dout_dp2  out  16  odd-phase sample x[2n+1] of dout_chn.
- dout_dv  out  1  output pair valid.
- dout_chn  out  8  output channel index.
- sync_out  out  1  first output pair after a sync_in.
- err_pulse  out  1  one-cycle pulse on a pairing error.

Behaviour:
- One clock, synchronous active-high reset (rst). Reset values:
  - all outputs 0;
  - phase = 0;
  - per-channel hold flags cleared;
  - sync_pending = 0.
- Input qualifying:
  - A sample is accepted only when din_dv = 1 and din_chn < NumChannelUsed.
  - All other cycles are no-ops; nothing is written and nothing is output.
- Phase register (1 bit):
  - Toggles after an accepted sample with din_chn = NumChannelUsed-1.
  - Accepted sample with sync_in = 1: that sample is treated as phase 0; phase is forced to 0 for the rest of that frame; sync_pending is set.
  - Simultaneous sync_in with din_chn = NumChannelUsed-1: phase 0 is used for that sample, then phase toggles to 1.
- Phase 0 accepted sample:
  - Write din_dq to hold RAM[din_chn] and set flag[din_chn].
  - If the flag was already set, overwrite the RAM entry and pulse err_pulse (lost pair).
  - No output.
- Phase 1 accepted sample, flag[din_chn] = 1:
  - Output dout_dp1 = RAM[din_chn], dout_dp2 = din_dq, dout_dv = 1, dout_chn = din_chn.
  - Clear the flag.
- Phase 1 accepted sample, flag[din_chn] = 0:
  - No output; pulse err_pulse.
- Latency: exactly 2 cycles from the accepted phase-1 input to dout_dv. Pipeline: synchronous RAM read, then output register.
- Read-during-write: a phase-0 write and a phase-1 read of the same channel cannot occur in the same cycle; no bypass is required.
- Non-valid output cycles: dout_dp1/dout_dp2/dout_chn hold their last values; dout_dv = 0.
- sync_out:
  - Asserted together with the first dout_dv after sync_pending is set, whatever its channel.
  - Clears sync_pending.
  - A new sync_in before that output re-arms sync_pending; at most one sync_out is produced.
- err_pulse: registered; same 2-cycle latency as the data path.
- Reset mid-frame: all held samples are discarded; the first subsequent phase-1 samples produce errors until a new phase-0 frame arrives.
- Throughput: back-to-back din_dv every cycle is supported; output duty is at most 50% of input valids.

Decomposition:
- Shared package prach_pkg:
  - NumChannel, NumChannelUsed, DataWidth constants;
  - channel-index typedef (logic [7:0]);
  - sample typedef (logic signed [15:0]).
- One sub-module, prach_tdm_ram: simple dual-port RAM, NumChannel x DataWidth, registered read, write-first not required.
- Flags, phase and sync logic live in the top module.

Test Plan:
- Nominal pairing: reset, then two full frames, ch 0..23, din_dq = 0x0100+ch in frame 0 and 0x0200+ch in frame 1, sync_in on frame 0 ch0.
  - Required: 24 outputs, dout_dp1 = 0x0100+ch, dout_dp2 = 0x0200+ch, each 2 cycles after the frame-1 input.
  - sync_out only on the ch0 output; err_pulse never asserted.
- Unused and invalid slots: frames driving ch 24..31 with din_dv = 1, plus gaps with din_dv = 0.
  - Required: no output for any of them, no errors, pairing of ch 0..23 unchanged.
- Resync: sync_in on a frame that would have been phase 1.
  - Required: that frame is stored as phase 0, the next frame pairs with it, and err_pulse fires for each ch whose flag was already set (24 pulses).
- Missing phase 0: reset, then feed a phase-1 frame only (sync_in never sent; phase starts at 0, so send 2 frames with the first dropped to din_dv = 0 for ch5).
  - Required: ch5 pair absent, one err_pulse, other 23 pairs correct.
- Reset mid-operation: assert rst after phase-0 ch0..11 are written, then send a complete sync'd frame pair.
  - Required: all outputs 0 during reset, no stale 0x01xx data appears, 24 correct pairs follow.
- Back-to-back throughput: continuous din_dv for 8 frames with ramp data.
  - Required: 96 output pairs, each with dout_dp2 - dout_dp1 equal to the per-frame ramp step; no errors.

Source files
------------

// File: rtl/prach_pkg.sv
// Shared constants and types for the PRACH half-band polyphase front end.
// Pure declarations: no latency, no flow control.
package prach_pkg;

  localparam int NumChannel     = 32;
  localparam int NumChannelUsed = 24;
  localparam int DataWidth      = 16;
  localparam int ChnAddrWidth   = $clog2(NumChannel);

  typedef logic [7:0]                  chn_t;
  typedef logic signed [DataWidth-1:0] sample_t;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  localparam chn_t ChnUsedLimit = chn_t'(NumChannelUsed);
  localparam chn_t ChnLast      = chn_t'(NumChannelUsed - 1);

  function automatic logic chn_in_use(input chn_t chn);
    return chn < ChnUsedLimit;
  endfunction

endpackage

// File: rtl/prach_hb2_demux_if.sv
// TDM sample stream in, even/odd sample pairs out; matches the half-band stage input.
// Wires only: no latency; valid-only flow, the consumer never stalls the stream.
interface prach_hb2_demux_if;
  import prach_pkg::*;

  sample_t din_dq;
  logic    din_dv;
  chn_t    din_chn;
  logic    sync_in;

  sample_t dout_dp1;
  sample_t dout_dp2;
  logic    dout_dv;
  chn_t    dout_chn;
  logic    sync_out;
  logic    err_pulse;

  modport master (
    output din_dq, din_dv, din_chn, sync_in,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_pulse
  );

  modport slave (
    input  din_dq, din_dv, din_chn, sync_in,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_pulse
  );

endinterface

// File: rtl/prach_tdm_ram.sv
// Per-channel sample hold store: simple dual-port RAM, read data registered (1 cycle).
// No flow control; a read and a write to the same address never coincide by construction.
module prach_tdm_ram #(
  parameter  int Depth     = 32,
  parameter  int Width     = 16,
  localparam int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [Width-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [Width-1:0]     rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/prach_hb2_demux.sv
// Pairs each channel's x[2n]/x[2n+1] from the TDM stream for the half-band decimator.
// Latency 2 cycles (RAM read, output register); accepts a sample every cycle, no backpressure.
module prach_hb2_demux
  import prach_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  prach_hb2_demux_if.slave       bus
);

  phase_t phase;
  phase_t phase_nxt;
  phase_t eff_phase;

  logic [NumChannel-1:0]   flag;
  logic [ChnAddrWidth-1:0] addr;
  logic                    accept;
  logic                    is_last;
  logic                    wr_en;
  logic                    rd_en;
  logic                    err_now;

  logic                    s1_vld;
  logic                    s1_err;
  chn_t                    s1_chn;
  sample_t                 s1_dp2;
  logic [DataWidth-1:0]    ram_rd;
  logic                    sync_pending;

  assign accept  = bus.din_dv && chn_in_use(bus.din_chn);
  assign addr    = bus.din_chn[ChnAddrWidth-1:0];
  assign is_last = (bus.din_chn == ChnLast);

  // A qualified sync forces its own sample to the even phase.
  assign eff_phase = bus.sync_in ? PH_EVEN : phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_EVEN;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    err_now   = 1'b0;
    if (accept) begin
      if (bus.sync_in) begin
        phase_nxt = is_last ? PH_ODD : PH_EVEN;
      end else if (is_last) begin
        phase_nxt = (phase == PH_EVEN) ? PH_ODD : PH_EVEN;
      end
      if (eff_phase == PH_EVEN) begin
        wr_en   = 1'b1;
        err_now = flag[addr];
      end else begin
        rd_en   = flag[addr];
        err_now = !flag[addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= '0;
    end else if (wr_en) begin
      flag[addr] <= 1'b1;
    end else if (rd_en) begin
      flag[addr] <= 1'b0;
    end
  end

  prach_tdm_ram #(
    .Depth (NumChannel),
    .Width (DataWidth)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (addr),
    .wr_data (bus.din_dq),
    .rd_en   (rd_en),
    .rd_addr (addr),
    .rd_data (ram_rd)
  );

  // Stage 1 runs alongside the RAM read so the odd sample lines up with its partner.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_err <= 1'b0;
      s1_chn <= '0;
      s1_dp2 <= '0;
    end else begin
      s1_vld <= rd_en;
      s1_err <= err_now;
      if (rd_en) begin
        s1_chn <= bus.din_chn;
        s1_dp2 <= bus.din_dq;
      end
    end
  end

  // A new sync wins over a same-cycle clear so it is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pending <= 1'b0;
    end else if (accept && bus.sync_in) begin
      sync_pending <= 1'b1;
    end else if (s1_vld) begin
      sync_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout_dv   <= 1'b0;
      bus.dout_dp1  <= '0;
      bus.dout_dp2  <= '0;
      bus.dout_chn  <= '0;
      bus.sync_out  <= 1'b0;
      bus.err_pulse <= 1'b0;
    end else begin
      bus.dout_dv   <= s1_vld;
      bus.sync_out  <= s1_vld && sync_pending;
      bus.err_pulse <= s1_err;
      if (s1_vld) begin
        bus.dout_dp1 <= sample_t'(ram_rd);
        bus.dout_dp2 <= s1_dp2;
        bus.dout_chn <= s1_chn;
      end
    end
  end

endmodule

// File: tb/tb_prach_hb2_demux.sv
// Directed bench for prach_hb2_demux: lock-step stimulus with a one-step-deep expectation
// that is checked two clock edges after each input, matching the pair output latency.
module tb_prach_hb2_demux;
  import prach_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   pair_cnt = 0;
  int   err_cnt = 0;

  logic        p_dv, p_sync, p_err;
  logic [15:0] p_p1, p_p2;
  logic [7:0]  p_chn;
  logic [15:0] last_p1, last_p2;
  logic [7:0]  last_chn;

  prach_hb2_demux_if bus ();

  prach_hb2_demux dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_expect();
    p_dv = 1'b0; p_sync = 1'b0; p_err = 1'b0;
    p_p1 = '0; p_p2 = '0; p_chn = '0;
    last_p1 = '0; last_p2 = '0; last_chn = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.din_dv = 1'b0; bus.sync_in = 1'b0; bus.din_chn = '0; bus.din_dq = '0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("rst_dv",   {31'd0, bus.dout_dv},   32'd0);
      check("rst_sync", {31'd0, bus.sync_out},  32'd0);
      check("rst_err",  {31'd0, bus.err_pulse}, 32'd0);
      check("rst_dp1",  {16'd0, bus.dout_dp1},  32'd0);
      check("rst_dp2",  {16'd0, bus.dout_dp2},  32'd0);
      check("rst_chn",  {24'd0, bus.dout_chn},  32'd0);
    end
    rst = 1'b0;
    clear_expect();
  endtask

  // Drive one input; the e_* arguments describe the output this input must cause.
  task automatic step(input logic dv, input logic [7:0] ch, input logic [15:0] dq, input logic sy,
                      input logic e_dv, input logic [15:0] e_p1, input logic [15:0] e_p2,
                      input logic e_sync, input logic e_err);
    bus.din_dv = dv; bus.din_chn = ch; bus.din_dq = dq; bus.sync_in = sy;
    @(posedge clk); #1;
    check("dout_dv",   {31'd0, bus.dout_dv},   {31'd0, p_dv});
    check("sync_out",  {31'd0, bus.sync_out},  {31'd0, p_sync});
    check("err_pulse", {31'd0, bus.err_pulse}, {31'd0, p_err});
    if (p_dv) begin
      last_p1 = p_p1; last_p2 = p_p2; last_chn = p_chn;
    end
    check("dout_dp1", {16'd0, bus.dout_dp1}, {16'd0, last_p1});
    check("dout_dp2", {16'd0, bus.dout_dp2}, {16'd0, last_p2});
    check("dout_chn", {24'd0, bus.dout_chn}, {24'd0, last_chn});
    if (bus.dout_dv === 1'b1) pair_cnt++;
    if (bus.err_pulse === 1'b1) err_cnt++;
    p_dv = e_dv; p_p1 = e_p1; p_p2 = e_p2; p_chn = ch; p_sync = e_sync; p_err = e_err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
  endtask

  // One frame of ch 0..nch-1 with data base+ch. In odd frames the pair partner is prev_base+ch.
  task automatic send_frame(input logic [15:0] base, input logic [15:0] prev_base, input logic odd,
                            input logic sy, input logic first_sync, input logic all_err,
                            input int skip_ch, input int miss_ch, input int nch, input logic extras);
    logic v, pair, err;
    for (int c = 0; c < nch; c++) begin
      v    = (c != skip_ch);
      pair = odd && v && (c != miss_ch);
      err  = v && (all_err || (odd && c == miss_ch));
      step(v, 8'(c), base + 16'(c), sy && (c == 0),
           pair, prev_base + 16'(c), base + 16'(c), pair && first_sync && (c == 0), err);
      if (extras && c == 11) begin
        step(1'b0, 8'd12, 16'h5555, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      end
    end
    if (extras) begin
      for (int c = 24; c < 32; c++) begin
        step(1'b1, 8'(c), 16'h7777, (c == 24), 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      end
      step(1'b1, 8'd200, 16'h6666, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      idle(2);
    end
  endtask

  initial begin
    bus.din_dv = 1'b0; bus.sync_in = 1'b0; bus.din_chn = '0; bus.din_dq = '0;
    clear_expect();

    do_reset(3);

    // Nominal pairing
    pair_cnt = 0; err_cnt = 0;
    send_frame(16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 24, 1'b0);
    send_frame(16'h0200, 16'h0100, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 24, 1'b0);
    idle(2);
    check("nominal_pairs", 32'(pair_cnt), 32'd24);
    check("nominal_errs",  32'(err_cnt),  32'd0);

    // Unused slots and gaps are no-ops
    pair_cnt = 0; err_cnt = 0;
    send_frame(16'h1100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 24, 1'b1);
    send_frame(16'h1200, 16'h1100, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 24, 1'b1);
    check("unused_pairs", 32'(pair_cnt), 32'd24);
    check("unused_errs",  32'(err_cnt),  32'd0);

    // Resync on a frame that would have been odd
    pair_cnt = 0; err_cnt = 0;
    send_frame(16'h2100, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 24, 1'b0);
    send_frame(16'h2200, 16'h2100, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 24, 1'b0);
    send_frame(16'h2300, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 24, 1'b0);
    send_frame(16'h2400, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, 24, 1'b0);
    send_frame(16'h2500, 16'h2400, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 24, 1'b0);
    idle(2);
    check("resync_pairs", 32'(pair_cnt), 32'd48);
    check("resync_errs",  32'(err_cnt),  32'd24);

    // Missing even sample for ch5
    do_reset(2);
    pair_cnt = 0; err_cnt = 0;
    send_frame(16'h3100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5, -1, 24, 1'b0);
    send_frame(16'h3200, 16'h3100, 1'b1, 1'b0, 1'b0, 1'b0, -1, 5, 24, 1'b0);
    idle(2);
    check("missing_pairs", 32'(pair_cnt), 32'd23);
    check("missing_errs",  32'(err_cnt),  32'd1);

    // Reset mid-frame discards held samples
    send_frame(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 12, 1'b0);
    do_reset(2);
    pair_cnt = 0; err_cnt = 0;
    send_frame(16'h4100, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 24, 1'b0);
    send_frame(16'h4200, 16'h4100, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 24, 1'b0);
    idle(2);
    check("midrst_pairs", 32'(pair_cnt), 32'd24);
    check("midrst_errs",  32'(err_cnt),  32'd0);

    // Back-to-back ramp, ramp step 0x40 per frame
    pair_cnt = 0; err_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      send_frame(16'h5000 + 16'(f * 16'h40), 16'h5000 + 16'(f * 16'h40) - 16'h40, f[0],
                 (f == 0), (f == 1), 1'b0, -1, -1, 24, 1'b0);
    end
    idle(2);
    check("ramp_step", {16'd0, 16'(bus.dout_dp2 - bus.dout_dp1)}, 32'h40);
    check("ramp_pairs", 32'(pair_cnt), 32'd96);
    check("ramp_errs",  32'(err_cnt),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
